// File: rtl/fc_argmax_if.sv
// Handshake and score bus between the final FC layer / host side and the
// argmax decision stage. The master drives requests and scores and consumes
// the result. The slave is the argmax engine.
interface fc_argmax_if #(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH       = 32,
   parameter int IDX_W       = 4
);
   logic                                  start;
   logic [NUM_CLASSES-1:0][WIDTH-1:0]     score_vec;
   logic                                  result_ready;
   logic                                  busy;
   logic                                  result_valid;
   logic [IDX_W-1:0]                      class_idx;
   logic [WIDTH-1:0]                      max_score;
   logic [WIDTH-1:0]                      margin;
   logic                                  overrun;

   modport master (
      output start, score_vec, result_ready,
      input  busy, result_valid, class_idx, max_score, margin, overrun
   );

   modport slave (
      input  start, score_vec, result_ready,
      output busy, result_valid, class_idx, max_score, margin, overrun
   );
endinterface

// File: rtl/fc_argmax.sv
// Classifier decision stage: scans a signed Q8.24 score vector one element
// per cycle and reports the winning index, winning score, and the saturated
// margin to the runner-up on a valid/ready handshake.
module fc_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH       = 32,
   parameter int IDX_W       = 4
) (
   input  logic          clk,
   input  logic          reset,   // asynchronous, active-low
   fc_argmax_if.slave    bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NUM_CLASSES - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

   // best - second in WIDTH+1 bits; best never falls below second, so the
   // difference is non-negative and only the upper bound needs clamping.
   function automatic logic [WIDTH-1:0] sat_margin(input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo);
      logic [WIDTH:0] diff;
      diff = {hi[WIDTH-1], hi} - {lo[WIDTH-1], lo};
      return (diff[WIDTH:WIDTH-1] != 2'b00) ? MOST_POS : diff[WIDTH-1:0];
   endfunction

   logic [1:0]       state_q,     state_d;
   logic [IDX_W-1:0] k_q,         k_d;
   logic [WIDTH-1:0] best_q,      best_d;
   logic [WIDTH-1:0] second_q,    second_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic [IDX_W-1:0] class_idx_q, class_idx_d;
   logic [WIDTH-1:0] max_score_q, max_score_d;
   logic [WIDTH-1:0] margin_q,    margin_d;
   logic             overrun_q,   overrun_d;

   logic             handshake;
   logic             accept;
   logic [WIDTH-1:0] cur_score;

   assign handshake = (state_q == S_HOLD) && bus.result_ready;
   // A start is taken when idle, or back-to-back on the result handshake.
   assign accept    = bus.start && ((state_q == S_IDLE) || handshake);
   // Scores are read live each scan cycle; the source holds them stable.
   assign cur_score = bus.score_vec[k_q];

   // Any start that is not accepted is reported one cycle later.
   assign overrun_d = bus.start && !accept;

   // Next-state and scan datapath: start a scan, compare one element, or retire.
   always_comb begin
      // NOTE: every _d starts from its current value so always_comb can never infer a latch.
      state_d     = state_q;
      k_d         = k_q;
      best_d      = best_q;
      second_d    = second_q;
      idx_d       = idx_q;
      class_idx_d = class_idx_q;
      max_score_d = max_score_q;
      margin_d    = margin_q;

      if (accept) begin
         best_d   = bus.score_vec[0];
         second_d = MOST_NEG;
         idx_d    = '0;
         k_d      = IDX_W'(1);
         if (NUM_CLASSES == 1) begin
            state_d     = S_HOLD;
            class_idx_d = '0;
            max_score_d = bus.score_vec[0];
            margin_d    = sat_margin(bus.score_vec[0], MOST_NEG);
         end else begin
            state_d = S_SCAN;
         end
      end else if (state_q == S_SCAN) begin
         // Strict compares: a tie keeps the lower index and drops to runner-up.
         if ($signed(cur_score) > $signed(best_q)) begin
            second_d = best_q;
            best_d   = cur_score;
            idx_d    = k_q;
         end else if ($signed(cur_score) > $signed(second_q)) begin
            second_d = cur_score;
         end
         k_d = k_q + 1'b1;
         if (k_q == LAST_K) begin
            state_d     = S_HOLD;
            class_idx_d = idx_d;
            max_score_d = best_d;
            margin_d    = sat_margin(best_d, second_d);
         end
      end else if (handshake) begin
         state_d = S_IDLE;
      end
   end

   // State, scan and result registers; reset aborts any scan in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: datapath registers are reset too, so outputs read 0 out of reset.
         state_q     <= S_IDLE;
         k_q         <= '0;
         best_q      <= '0;
         second_q    <= '0;
         idx_q       <= '0;
         class_idx_q <= '0;
         max_score_q <= '0;
         margin_q    <= '0;
         overrun_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         k_q         <= k_d;
         best_q      <= best_d;
         second_q    <= second_d;
         idx_q       <= idx_d;
         class_idx_q <= class_idx_d;
         max_score_q <= max_score_d;
         margin_q    <= margin_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.result_valid = (state_q == S_HOLD);
   assign bus.class_idx    = class_idx_q;
   assign bus.max_score    = max_score_q;
   assign bus.margin       = margin_q;
   assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Testbench for fc_argmax: directed cases plus randomized score vectors,
// checked by a scoreboard fed from a sort-style reference model.
module tb_fc_argmax;

   localparam int NC = 10;
   localparam int W  = 32;
   localparam int IW = 4;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  mx;
      logic [W-1:0]  mg;
   } exp_t;

   logic clk;
   logic rst_n;

   fc_argmax_if #(.NUM_CLASSES(NC), .WIDTH(W), .IDX_W(IW)) bus();

   fc_argmax #(.NUM_CLASSES(NC), .WIDTH(W), .IDX_W(IW)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   logic [W-1:0] cur [NC];
   logic [W-1:0] pool [5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'h0100_0000, 32'hFF00_0000};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint sx(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   // Winner = largest value, lowest index on ties. Runner-up = largest of
   // the remaining elements (so a duplicate of the winner gives margin 0).
   function automatic exp_t ref_model(input logic [W-1:0] v [NC]);
      exp_t   r;
      int     bi;
      longint best;
      longint second;
      longint m;
      bi   = 0;
      best = sx(v[0]);
      for (int j = 1; j < NC; j++)
         if (sx(v[j]) > best) begin
            best = sx(v[j]);
            bi   = j;
         end
      second = -(64'sd1 <<< (W - 1));
      for (int j = 0; j < NC; j++)
         if (j != bi && sx(v[j]) > second) second = sx(v[j]);
      m = best - second;
      if (m > ((64'sd1 <<< (W - 1)) - 1)) m = (64'sd1 <<< (W - 1)) - 1;
      r.idx = IW'(bi);
      r.mx  = v[bi];
      r.mg  = W'(m);
      return r;
   endfunction

   // Monitor: every handshake the DUT presents is compared to the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.result_valid && bus.result_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: idx=%0d score=0x%0h with no pending request",
                     bus.class_idx, bus.max_score);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_class_idx", 64'(bus.class_idx), 64'(e.idx));
            check("sb_max_score", 64'(bus.max_score), 64'(e.mx));
            check("sb_margin",    64'(bus.margin),    64'(e.mg));
         end
      end
   end

   task automatic apply_scores();
      for (int i = 0; i < NC; i++) bus.score_vec[i] = cur[i];
   endtask

   task automatic set_all(input logic [W-1:0] val);
      for (int i = 0; i < NC; i++) cur[i] = val;
   endtask

   function automatic logic [W-1:0] rand_score();
      case ($urandom_range(0, 3))
         0:       return W'($urandom);
         1:       return pool[$urandom_range(0, 4)];
         2:       return W'($urandom_range(0, 3)) << 24;
         default: return -(W'($urandom_range(0, 3)) << 24);
      endcase
   endfunction

   // Pulse start for one edge with the current scores and queue the expectation.
   task automatic do_start();
      apply_scores();
      bus.start = 1'b1;
      exp_q.push_back(ref_model(cur));
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat, input string name);
      int n = 0;
      while (!bus.result_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic check_result(input string name, input logic [IW-1:0] idx,
                               input logic [W-1:0] mx, input logic [W-1:0] mg);
      check({name, "_valid"}, 64'(bus.result_valid), 64'd1);
      check({name, "_idx"},   64'(bus.class_idx),    64'(idx));
      check({name, "_max"},   64'(bus.max_score),    64'(mx));
      check({name, "_margin"},64'(bus.margin),       64'(mg));
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_busy"},    64'(bus.busy),         64'd0);
      check({name, "_valid"},   64'(bus.result_valid), 64'd0);
      check({name, "_idx"},     64'(bus.class_idx),    64'd0);
      check({name, "_max"},     64'(bus.max_score),    64'd0);
      check({name, "_margin"},  64'(bus.margin),       64'd0);
      check({name, "_overrun"}, 64'(bus.overrun),      64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e4;
      bit   in_hold;

      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.result_ready = 1'b0;
      set_all('0);
      apply_scores();
      #12;
      check_zero_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Case 1: single winner.
      bus.result_ready = 1'b1;
      set_all(32'hFF00_0000);
      cur[7] = 32'h0300_0000;
      cur[2] = 32'h0180_0000;
      do_start();
      check("c1_busy", 64'(bus.busy), 64'd1);
      wait_valid(NC - 1, "c1");
      check_result("c1", 4'd7, 32'h0300_0000, 32'h0180_0000);
      @(posedge clk); #1;
      check("c1_idle_valid", 64'(bus.result_valid), 64'd0);
      check("c1_idle_busy",  64'(bus.busy),         64'd0);

      // Case 2: tie, plus a start dropped during SCAN.
      set_all('0);
      cur[3] = 32'h0200_0000;
      cur[8] = 32'h0200_0000;
      do_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("scan_overrun", 64'(bus.overrun), 64'd1);
      @(posedge clk); #1;
      check("scan_overrun_end", 64'(bus.overrun), 64'd0);
      wait_valid(NC - 3, "c2");
      check_result("c2", 4'd3, 32'h0200_0000, 32'h0);
      @(posedge clk); #1;

      // Case 3: all equal negative.
      set_all(32'hFF80_0000);
      do_start();
      wait_valid(NC - 1, "c3");
      check_result("c3", 4'd0, 32'hFF80_0000, 32'h0);
      @(posedge clk); #1;

      // Case 4: backpressure with an ignored start, then back-to-back restart.
      bus.result_ready = 1'b0;
      for (int i = 0; i < NC; i++) cur[i] = W'(i) << 20;
      e4 = ref_model(cur);
      do_start();
      wait_valid(NC - 1, "c4");
      for (int i = 0; i < 5; i++) begin
         if (i == 1) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         check_result("c4_hold", e4.idx, e4.mx, e4.mg);
         check("c4_overrun", 64'(bus.overrun), 64'(i == 1));
      end
      set_all(32'hFF00_0000);
      cur[7] = 32'h0300_0000;
      cur[2] = 32'h0180_0000;
      bus.result_ready = 1'b1;
      do_start();
      check("c4_b2b_valid", 64'(bus.result_valid), 64'd0);
      check("c4_b2b_busy",  64'(bus.busy),         64'd1);
      wait_valid(NC - 1, "c4_b2b");
      check_result("c4_b2b", 4'd7, 32'h0300_0000, 32'h0180_0000);
      @(posedge clk); #1;
      check("c4_idle_busy", 64'(bus.busy), 64'd0);

      // Case 4b: leave a result pending so reset is seen clearing non-zero outputs.
      bus.result_ready = 1'b0;
      set_all(32'h0100_0000);
      do_start();
      wait_valid(NC - 1, "c5_pre");
      bus.result_ready = 1'b1;
      do_start();
      repeat (3) @(posedge clk);
      #1;
      // Case 5: reset on scan cycle 4 aborts the scan.
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      check_zero_outputs("c5_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_all(32'hFF00_0000);
      cur[7] = 32'h0300_0000;
      cur[2] = 32'h0180_0000;
      do_start();
      wait_valid(NC - 1, "c5");
      check_result("c5", 4'd7, 32'h0300_0000, 32'h0180_0000);
      @(posedge clk); #1;

      // Case 6: margin saturation.
      set_all(32'h8000_0000);
      cur[5] = 32'h7FFF_FFFF;
      do_start();
      wait_valid(NC - 1, "c6");
      check_result("c6", 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      @(posedge clk); #1;
      bus.result_ready = 1'b0;

      // Randomized vectors with random backpressure and back-to-back starts.
      in_hold = 1'b0;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < NC; i++) cur[i] = rand_score();
         if (in_hold) bus.result_ready = 1'b1;
         do_start();
         bus.result_ready = 1'b0;
         wait_valid(NC - 1, "rnd");
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         in_hold = 1'($urandom_range(0, 1));
         if (!in_hold) begin
            bus.result_ready = 1'b1;
            @(posedge clk); #1;
            bus.result_ready = 1'b0;
            check("rnd_idle_busy", 64'(bus.busy), 64'd0);
         end
      end
      if (in_hold) begin
         bus.result_ready = 1'b1;
         @(posedge clk); #1;
         bus.result_ready = 1'b0;
      end

      @(posedge clk); #1;
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
